seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter W, default 32, meaning operand/result width; legal values are powers of two from 8 to 64.
REQ-002 Parameter SW, default $clog2(W), meaning shift-amount width taken from operand b[SW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  4  operation code from the shared op enum.
REQ-008 a, b  input  W each  operands.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  W  low result (MUL low word, DIV quotient).
REQ-012 result_hi  output  W  MUL high word, DIV remainder, otherwise 0.
REQ-013 zero  output  1  result == 0.
REQ-014 ovf  output  1  signed overflow on ADD/SUB only, otherwise 0.
REQ-015 err  output  1  illegal op code; result, result_hi and ovf are 0.

Function
REQ-016 Ops: ADD, SUB, AND, OR, XOR, NOR(~(a|b)), SLL, SRL, SRA, SLT, SLTU, LUI({b[W/2-1:0],W/2 zeros}), MUL, MULU, DIV, DIVU.
REQ-017 FSM states: IDLE, MUL, DIV, DONE; in_ready = (state==IDLE).
REQ-018 Accept on in_valid && in_ready; operands and op are registered on accept, so later input changes have no effect.
REQ-019 Single-cycle ops: IDLE->DONE; out_valid rises on the cycle after accept.
REQ-020 MUL/MULU: IDLE->MUL; shift-add, one bit per cycle, W cycles; then DONE; out_valid rises W+1 cycles after accept.
REQ-021 DIV/DIVU: IDLE->DIV; restoring division, one bit per cycle, W cycles; then DONE; out_valid rises W+1 cycles after accept.
REQ-022 Signed MUL/DIV: operate on magnitudes, then correct signs; the remainder takes the dividend's sign.
REQ-023 Divide by zero: result = all ones, result_hi = a, err = 0.
REQ-024 Signed DIV of most-negative value by -1: result = a, result_hi = 0.
REQ-025 DONE: outputs are held stable while out_valid && !out_ready; on out_ready the FSM goes to DONE->IDLE, so the next accept is no earlier than the following cycle.
REQ-026 Back-to-back single-cycle throughput is one op per 2 cycles with out_ready tied high.
REQ-027 Shifts use only b[SW-1:0]; SRA replicates a[W-1].
REQ-028 SLT compares signed, SLTU compares unsigned; result is 1 or 0 zero-extended.
REQ-029 ADD/SUB wrap modulo 2^W; ovf = operand signs agree (for SUB, a and ~b) and the result sign differs.
REQ-030 zero, ovf and err are registered with result and valid only while out_valid = 1.

Reset
REQ-031 rst_n low forces IDLE immediately, regardless of clk, including mid-MUL/DIV or mid-DONE; the in-flight op is discarded.
REQ-032 Reset values: out_valid=0, result=0, result_hi=0, zero=0, ovf=0, err=0, iteration counter=0; in_ready=1 from the first clock after rst_n deasserts.

Structure
REQ-033 Package alu_pkg holds the op enum (4-bit), the FSM state enum and the localparam for illegal-op detection.
REQ-034 One sub-module, muldiv_iter, holds the shared W-cycle shift register/adder datapath and counter for MUL and DIV; single-cycle ops live in seq_alu.

Verification
REQ-035 ADD a=32'h7FFFFFFF b=1 -> out_valid one cycle after accept; result=32'h80000000, ovf=1, zero=0.
REQ-036 MUL a=-3 b=7 -> out_valid 33 cycles after accept; result=32'hFFFFFFEB, result_hi=32'hFFFFFFFF.
REQ-037 DIV a=-7 b=2 -> result=32'hFFFFFFFD (-3), result_hi=32'hFFFFFFFF (-1); DIVU a=100 b=0 -> result=32'hFFFFFFFF, result_hi=100.
REQ-038 SRA a=32'h80000000 b=32'h24 -> shift 4, result=32'hF8000000; holding out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout.
REQ-039 Assert rst_n=0 mid-cycle at iteration 10 of DIVU -> out_valid=0 and in_ready=1 after release; the next ADD 2+2 returns 4.
REQ-040 op = unused code -> err=1, result=0, zero=1, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state definitions for the sequential ALU and its iterative
// multiply/divide datapath.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOR  = 4'h5,
        OP_SLL  = 4'h6,
        OP_SRL  = 4'h7,
        OP_SRA  = 4'h8,
        OP_SLT  = 4'h9,
        OP_SLTU = 4'hA,
        OP_LUI  = 4'hB,
        OP_MUL  = 4'hC,
        OP_MULU = 4'hD,
        OP_DIV  = 4'hE,
        OP_DIVU = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } alu_state_e;

    // One bit per opcode; a cleared bit makes that code report err.
    // All sixteen codes of the 4-bit space are currently assigned.
    localparam logic [15:0] OP_LEGAL_MASK = 16'hFFFF;

    function automatic logic op_is_legal(input logic [3:0] code);
        return OP_LEGAL_MASK[code];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative W-cycle shift-add multiplier / restoring divider shared by
// MUL, MULU, DIV and DIVU; works on magnitudes and sign-corrects the result.
module muldiv_iter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_div,
    input  logic         is_signed,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         last,
    output logic [W-1:0] res_lo,
    output logic [W-1:0] res_hi
);
    import alu_pkg::*;

    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          div_q, div_d;
    logic          neg_lo_q, neg_lo_d;
    logic          neg_hi_q, neg_hi_d;
    logic          dz_q, dz_d;

    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     sum;
    logic [W:0]     trial;
    logic [2*W-1:0] prod, prod_s;
    logic [W-1:0]   quo_s, rem_s;

    always_comb begin
        a_mag = (is_signed && a[W-1]) ? -a : a;
        b_mag = (is_signed && b[W-1]) ? -b : b;
        sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
        trial = {acc_q, sh_q[W-1]} - {1'b0, opnd_q};

        acc_d    = acc_q;
        sh_d     = sh_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;

        if (start) begin
            acc_d    = '0;
            sh_d     = a_mag;
            opnd_d   = b_mag;
            cnt_d    = '0;
            busy_d   = 1'b1;
            div_d    = is_div;
            neg_lo_d = is_signed && (a[W-1] ^ b[W-1]);
            neg_hi_d = is_signed && a[W-1];
            dz_d     = (b == '0);
        end else if (busy_q) begin
            if (div_q) begin
                // Restoring step: keep the trial remainder only if it did not go negative.
                if (!trial[W]) begin
                    acc_d = trial[W-1:0];
                    sh_d  = {sh_q[W-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[W-2:0], sh_q[W-1]};
                    sh_d  = {sh_q[W-2:0], 1'b0};
                end
            end else begin
                acc_d = sum[W:1];
                sh_d  = {sum[0], sh_q[W-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // Results are formed from the post-step values so the caller can capture
    // them on the same edge as the final iteration.
    always_comb begin
        prod   = {acc_d, sh_d};
        prod_s = neg_lo_q ? -prod : prod;
        quo_s  = neg_lo_q ? -sh_d : sh_d;
        rem_s  = neg_hi_q ? -acc_d : acc_d;
        if (div_q) begin
            res_lo = dz_q ? '1 : quo_s;
            res_hi = rem_s;
        end else begin
            res_lo = prod_s[W-1:0];
            res_hi = prod_s[2*W-1:W];
        end
    end

    assign last = busy_q && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            sh_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake: single-cycle logic/arith ops
// computed here, multi-cycle MUL/DIV delegated to muldiv_iter.
module seq_alu #(
    parameter int unsigned W  = 32,
    parameter int unsigned SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [W-1:0] result_hi,
    output logic         zero,
    output logic         ovf,
    output logic         err
);
    import alu_pkg::*;

    alu_state_e   state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] result_q, result_d;
    logic [W-1:0] result_hi_q, result_hi_d;
    logic         zero_q, zero_d;
    logic         ovf_q, ovf_d;
    logic         err_q, err_d;

    alu_op_e      op_e;
    logic [W-1:0] alu_res;
    logic         alu_ovf;
    logic [W-1:0] sum, diff;
    logic [SW-1:0] shamt;

    logic         md_start, md_is_div, md_is_signed, md_last;
    logic [W-1:0] md_lo, md_hi;

    assign op_e         = alu_op_e'(op);
    assign shamt        = b[SW-1:0];
    assign md_is_div    = (op_e == OP_DIV) || (op_e == OP_DIVU);
    assign md_is_signed = (op_e == OP_MUL) || (op_e == OP_DIV);

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_e)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = W'($signed(a) >>> shamt);
            OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(W-1){1'b0}}, (a < b)};
            OP_LUI:  alu_res = {b[W/2-1:0], {(W/2){1'b0}}};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        md_start    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (!op_is_legal(op)) begin
                        result_d    = '0;
                        result_hi_d = '0;
                        zero_d      = 1'b1;
                        ovf_d       = 1'b0;
                        err_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        case (op_e)
                            OP_MUL, OP_MULU: begin
                                md_start = 1'b1;
                                state_d  = ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                md_start = 1'b1;
                                state_d  = ST_DIV;
                            end
                            default: begin
                                result_d    = alu_res;
                                result_hi_d = '0;
                                zero_d      = (alu_res == '0);
                                ovf_d       = alu_ovf;
                                err_d       = 1'b0;
                                out_valid_d = 1'b1;
                                state_d     = ST_DONE;
                            end
                        endcase
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_last) begin
                    result_d    = md_lo;
                    result_hi_d = md_hi;
                    zero_d      = (md_lo == '0);
                    ovf_d       = 1'b0;
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    muldiv_iter #(.W(W)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .is_div    (md_is_div),
        .is_signed (md_is_signed),
        .a         (a),
        .b         (b),
        .last      (md_last),
        .res_lo    (md_lo),
        .res_hi    (md_hi)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table through a scoreboard queue,
// plus hand-written hold, throughput and mid-operation reset sequences.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result, result_hi;
    logic        zero, ovf, err;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        o;
        logic        e;
        int unsigned lat;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    time  t_acc;

    seq_alu #(.W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input alu_op_e o, input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] r, input logic [31:0] h,
                                input logic z, input logic ov, input logic e,
                                input int unsigned lat);
        vec_t v;
        v.op = 4'(o); v.a = va; v.b = vb; v.res = r; v.hi = h;
        v.z = z; v.o = ov; v.e = e; v.lat = lat;
        return v;
    endfunction

    // Drive one request, then compare when the result appears.
    task automatic issue(input vec_t v, input string tag);
        vec_t e;
        int   n;
        int unsigned lat;
        sb.push_back(v);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready_wait"}, 64'(n < 200), 64'd1);
        in_valid = 1'b1;
        op = v.op;
        a = v.a;
        b = v.b;
        @(posedge clk);
        t_acc = $time;
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 4'($urandom_range(0, 15));
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, ".lat"}, 64'(lat), 64'(e.lat));
        chk({tag, ".res"}, 64'(result), 64'(e.res));
        chk({tag, ".hi"}, 64'(result_hi), 64'(e.hi));
        chk({tag, ".zero"}, 64'(zero), 64'(e.z));
        chk({tag, ".ovf"}, 64'(ovf), 64'(e.o));
        chk({tag, ".err"}, 64'(err), 64'(e.e));
    endtask

    initial begin
        time t1;
        int unsigned n;

        tbl.push_back(mk(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk(OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_SLL,  32'h00000001, 32'h00000025, 32'h00000020, 32'h0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_LUI,  32'h12345678, 32'h0000ABCD, 32'hABCD0000, 32'h0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_MUL,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33));
        tbl.push_back(mk(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33));
        tbl.push_back(mk(OP_MUL,  32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 33));
        tbl.push_back(mk(OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33));
        tbl.push_back(mk(OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 1'b0, 33));
        tbl.push_back(mk(OP_DIVU, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 32'h00000064, 1'b0, 1'b0, 1'b0, 33));
        tbl.push_back(mk(OP_DIVU, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 1'b0, 1'b0, 33));
        tbl.push_back(mk(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 33));

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = '0;
        a = '0;
        b = '0;
        #12;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.result_hi", 64'(result_hi), 64'd0);
        chk("rst.flags", 64'({zero, ovf, err}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < tbl.size(); i++)
            issue(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back single-cycle ops: one accept every two cycles.
        issue(mk(OP_ADD, 32'd1, 32'd2, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1), "b2b0");
        t1 = t_acc;
        issue(mk(OP_ADD, 32'd3, 32'd4, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1), "b2b1");
        chk("b2b.interval", 64'(t_acc - t1), 64'd20);

        // SRA result held while the consumer stalls.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(mk(OP_SRA, 32'h80000000, 32'h00000024, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0, 1), "sra");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d.valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("hold%0d.in_ready", i), 64'(in_ready), 64'd0);
            chk($sformatf("hold%0d.res", i), 64'(result), 64'hF8000000);
            chk($sformatf("hold%0d.hi", i), 64'(result_hi), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold.release", 64'(out_valid), 64'd0);

        // Reset during iteration 10 of a DIVU discards the operation.
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rstdiv.ready_wait", 64'(n < 200), 64'd1);
        in_valid = 1'b1;
        op = 4'(OP_DIVU);
        a = 32'd1000;
        b = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstdiv.valid_low", 64'(out_valid), 64'd0);
        chk("rstdiv.result", 64'(result), 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstdiv.in_ready", 64'(in_ready), 64'd1);
        chk("rstdiv.valid", 64'(out_valid), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("rstdiv.no_result", 64'(out_valid), 64'd0);
        issue(mk(OP_ADD, 32'd2, 32'd2, 32'd4, 32'h0, 1'b0, 1'b0, 1'b0, 1), "post_rst");

        chk("sb.empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
